// File: rtl/le_prefix_sequencer.sv
// Low-entropy prefix sequencer: builds a candidate prefix one symbol at a time,
// queries an external codebook, and emits codewords or flush records.
// Optional codeword counter is enabled by defining LE_SEQ_STATS_EN.
module le_prefix_sequencer #(
    parameter int CODEBOOK_LENGTH_MAX = 64,
    parameter int ENCODE_DATALENGTH   = 21,
    parameter int MAX_DEPTH           = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           sym_valid_i,
    input  logic [3:0]                     sym_i,
    output logic                           sym_ready_o,
    input  logic                           flush_i,
    output logic [5:0]                     ap_cnt_o,
    output logic [CODEBOOK_LENGTH_MAX-1:0] ap_data_o,
    input  logic                           encode_match_i,
    input  logic [5:0]                     encode_length_i,
    input  logic [ENCODE_DATALENGTH-1:0]   encode_data_i,
    output logic                           cw_valid_o,
    input  logic                           cw_ready_i,
    output logic [ENCODE_DATALENGTH-1:0]   cw_data_o,
    output logic [5:0]                     cw_length_o,
    output logic                           cw_flush_o,
    output logic [5:0]                     flush_cnt_o,
    output logic [CODEBOOK_LENGTH_MAX-1:0] flush_data_o,
    output logic                           flush_done_o,
    output logic                           overflow_o,
    output logic                           busy_o,
    output logic [15:0]                    cw_count_o
);

    // state  | meaning
    // IDLE   | waiting for a symbol or a flush request
    // LOOKUP | candidate driven to the codebook, result sampled at cycle end
    // EMIT   | output word held until downstream accepts it
    // FLUSH  | partial prefix is packed into a flush record (or just acknowledged)
    typedef enum logic [1:0] {IDLE, LOOKUP, EMIT, FLUSH} state_t;

    localparam logic [5:0] DEPTH_MAX = 6'(MAX_DEPTH);

    state_t                         state;
    logic [CODEBOOK_LENGTH_MAX-1:0] prefix;
    logic [5:0]                     pfx_len;
    logic                           flush_pend;
    logic [5:0]                     pfx_len_inc;

    assign pfx_len_inc = pfx_len + 6'd1;
    assign busy_o      = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            prefix       <= '0;
            pfx_len      <= '0;
            flush_pend   <= 1'b0;
            sym_ready_o  <= 1'b0;
            ap_cnt_o     <= '0;
            ap_data_o    <= '0;
            cw_valid_o   <= 1'b0;
            cw_data_o    <= '0;
            cw_length_o  <= '0;
            cw_flush_o   <= 1'b0;
            flush_cnt_o  <= '0;
            flush_data_o <= '0;
            flush_done_o <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            // Query port is zero except for the single LOOKUP cycle.
            ap_cnt_o     <= '0;
            ap_data_o    <= '0;
            flush_done_o <= 1'b0;
            if (flush_i && (state != IDLE || sym_valid_i))
                flush_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (sym_valid_i) begin
                        ap_cnt_o    <= pfx_len_inc;
                        ap_data_o   <= {prefix[CODEBOOK_LENGTH_MAX-5:0], sym_i};
                        sym_ready_o <= 1'b0;
                        state       <= LOOKUP;
                    end else if (flush_i || flush_pend) begin
                        sym_ready_o <= 1'b0;
                        state       <= FLUSH;
                    end else begin
                        sym_ready_o <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (encode_match_i) begin
                        cw_data_o   <= encode_data_i;
                        cw_length_o <= encode_length_i;
                        cw_flush_o  <= 1'b0;
                        cw_valid_o  <= 1'b1;
                        prefix      <= '0;
                        pfx_len     <= '0;
                        state       <= EMIT;
                    end else if (pfx_len_inc < DEPTH_MAX) begin
                        prefix      <= ap_data_o;
                        pfx_len     <= pfx_len_inc;
                        sym_ready_o <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        // Candidate is full and unmatched: drop it along with the symbol.
                        overflow_o  <= 1'b1;
                        prefix      <= '0;
                        pfx_len     <= '0;
                        sym_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                EMIT: begin
                    if (cw_ready_i) begin
                        cw_valid_o   <= 1'b0;
                        flush_done_o <= cw_flush_o;
                        sym_ready_o  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                FLUSH: begin
                    // The request being serviced here must not re-arm itself.
                    flush_pend <= 1'b0;
                    if (pfx_len == 6'd0) begin
                        flush_done_o <= 1'b1;
                        sym_ready_o  <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        cw_flush_o   <= 1'b1;
                        flush_cnt_o  <= pfx_len;
                        flush_data_o <= prefix;
                        cw_data_o    <= '0;
                        cw_length_o  <= '0;
                        cw_valid_o   <= 1'b1;
                        prefix       <= '0;
                        pfx_len      <= '0;
                        state        <= EMIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LE_SEQ_STATS_EN
    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            cw_count_o <= '0;
        else if (state == EMIT && cw_ready_i && !cw_flush_o && cw_count_o != 16'hFFFF)
            cw_count_o <= cw_count_o + 16'd1;
    end
`else
    assign cw_count_o = '0;
`endif

endmodule

// File: tb/tb_le_prefix_sequencer.sv
// Directed bench for le_prefix_sequencer: default instance plus a MAX_DEPTH=4
// instance sharing stimulus, each with a small behavioural codebook attached.
module tb_le_prefix_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, sym_valid, flush, cw_ready;
    logic [3:0]  sym;
    int          total = 0;
    int          bad   = 0;

`ifdef LE_SEQ_STATS_EN
    localparam logic [15:0] CNT_EXP = 16'd1;
`else
    localparam logic [15:0] CNT_EXP = 16'd0;
`endif

    // Main instance
    logic        sym_ready, cw_valid, cw_flush, flush_done, overflow, busy;
    logic        enc_match;
    logic [5:0]  ap_cnt, enc_len, cw_length, flush_cnt;
    logic [63:0] ap_data, flush_data;
    logic [20:0] enc_data, cw_data;
    logic [15:0] cw_count;

    // MAX_DEPTH=4 instance
    logic        sym_ready4, cw_valid4, cw_flush4, flush_done4, overflow4, busy4;
    logic        enc_match4;
    logic [5:0]  ap_cnt4, enc_len4, cw_length4, flush_cnt4;
    logic [63:0] ap_data4, flush_data4;
    logic [20:0] enc_data4, cw_data4;
    logic [15:0] cw_count4;

    always #5 clk = ~clk;

    // Test codebook: returns {match, length, data}.
    function automatic logic [27:0] cb(input logic [5:0] cnt, input logic [63:0] d);
        if (cnt == 6'd1 && d == 64'hF)    return {1'b1, 6'd6,  21'b101000};
        if (cnt == 6'd4 && d == 64'h001F) return {1'b1, 6'd12, 21'hFF9};
        if (cnt == 6'd2 && d == 64'h2F)   return {1'b1, 6'd8,  21'b11011001};
        return '0;
    endfunction

    assign {enc_match,  enc_len,  enc_data}  = cb(ap_cnt,  ap_data);
    assign {enc_match4, enc_len4, enc_data4} = cb(ap_cnt4, ap_data4);

    le_prefix_sequencer dut (
        .clk_i(clk), .rst_n_i(rst_n), .sym_valid_i(sym_valid), .sym_i(sym),
        .sym_ready_o(sym_ready), .flush_i(flush), .ap_cnt_o(ap_cnt), .ap_data_o(ap_data),
        .encode_match_i(enc_match), .encode_length_i(enc_len), .encode_data_i(enc_data),
        .cw_valid_o(cw_valid), .cw_ready_i(cw_ready), .cw_data_o(cw_data),
        .cw_length_o(cw_length), .cw_flush_o(cw_flush), .flush_cnt_o(flush_cnt),
        .flush_data_o(flush_data), .flush_done_o(flush_done), .overflow_o(overflow),
        .busy_o(busy), .cw_count_o(cw_count)
    );

    le_prefix_sequencer #(.MAX_DEPTH(4)) dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .sym_valid_i(sym_valid), .sym_i(sym),
        .sym_ready_o(sym_ready4), .flush_i(flush), .ap_cnt_o(ap_cnt4), .ap_data_o(ap_data4),
        .encode_match_i(enc_match4), .encode_length_i(enc_len4), .encode_data_i(enc_data4),
        .cw_valid_o(cw_valid4), .cw_ready_i(cw_ready), .cw_data_o(cw_data4),
        .cw_length_o(cw_length4), .cw_flush_o(cw_flush4), .flush_cnt_o(flush_cnt4),
        .flush_data_o(flush_data4), .flush_done_o(flush_done4), .overflow_o(overflow4),
        .busy_o(busy4), .cw_count_o(cw_count4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one symbol; returns at the negedge of the LOOKUP cycle.
    task automatic send(input logic [3:0] s);
        int n = 0;
        while (!sym_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", sym_ready, 1);
        sym_valid = 1'b1;
        sym       = s;
        @(negedge clk);
        sym_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; sym_valid = 1'b0; sym = 4'h0; flush = 1'b0; cw_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready",  sym_ready, 0);
        chk("rst_valid",  cw_valid, 0);
        chk("rst_busy",   busy, 0);
        chk("rst_ovf",    overflow, 0);
        chk("rst_count",  cw_count, 0);
        chk("rst_apcnt",  ap_cnt, 0);
        chk("rst_fdone",  flush_done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", sym_ready, 1);

        // Single-symbol codeword
        send(4'hF);
        chk("t1_apcnt",  ap_cnt, 1);
        chk("t1_apdata", ap_data, 64'hF);
        @(negedge clk);
        chk("t1_valid", cw_valid, 1);
        chk("t1_len",   cw_length, 6);
        chk("t1_data",  cw_data, 21'b101000);
        chk("t1_flush", cw_flush, 0);
        @(negedge clk);
        chk("t1_busy",   busy, 0);
        chk("t1_ready",  sym_ready, 1);
        chk("t1_apidle", ap_cnt, 0);

        // Three misses then a four-nibble hit
        send(4'h0); @(negedge clk);
        chk("t2_miss_ready", sym_ready, 1);
        chk("t2_miss_valid", cw_valid, 0);
        send(4'h0); @(negedge clk);
        send(4'h1); @(negedge clk);
        send(4'hF);
        chk("t2_apcnt",  ap_cnt, 4);
        chk("t2_apdata", ap_data, 64'h001F);
        @(negedge clk);
        chk("t2_valid", cw_valid, 1);
        chk("t2_len",   cw_length, 12);
        chk("t2_data",  cw_data, 21'hFF9);
        @(negedge clk);
        send(4'hF);
        chk("t2_pfx_clear", ap_cnt, 1);
        @(negedge clk); @(negedge clk);

        // Flush of a partial prefix, then an empty flush
        send(4'h2); @(negedge clk);
        send(4'h2); @(negedge clk);
        flush = 1'b1; @(negedge clk); flush = 1'b0;
        chk("t3_busy",   busy, 1);
        chk("t3_fdone0", flush_done, 0);
        @(negedge clk);
        chk("t3_valid",  cw_valid, 1);
        chk("t3_flush",  cw_flush, 1);
        chk("t3_fcnt",   flush_cnt, 2);
        chk("t3_fdata",  flush_data, 64'h22);
        chk("t3_cwdata", cw_data, 0);
        chk("t3_cwlen",  cw_length, 0);
        @(negedge clk);
        chk("t3_fdone",  flush_done, 1);
        chk("t3_idle_valid", cw_valid, 0);
        flush = 1'b1; @(negedge clk); flush = 1'b0;
        chk("t3b_fdone0", flush_done, 0);
        @(negedge clk);
        chk("t3b_fdone", flush_done, 1);
        chk("t3b_valid", cw_valid, 0);
        @(negedge clk);
        chk("t3b_fdone_pulse", flush_done, 0);

        // Flush arriving together with a symbol: symbol first, then flush record
        sym_valid = 1'b1; sym = 4'h3; flush = 1'b1;
        @(negedge clk);
        sym_valid = 1'b0; flush = 1'b0;
        chk("t3c_apcnt",  ap_cnt, 1);
        chk("t3c_apdata", ap_data, 64'h3);
        n = 0;
        while (!cw_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t3c_valid", cw_valid, 1);
        chk("t3c_flush", cw_flush, 1);
        chk("t3c_fcnt",  flush_cnt, 1);
        chk("t3c_fdata", flush_data, 64'h3);
        @(negedge clk);
        chk("t3c_fdone", flush_done, 1);

        rst_n = 1'b0; @(negedge clk); @(negedge clk); rst_n = 1'b1; @(negedge clk);

        // Backpressure hold
        cw_ready = 1'b0;
        send(4'h2); @(negedge clk);
        send(4'hF);
        chk("t5_apcnt",  ap_cnt, 2);
        chk("t5_apdata", ap_data, 64'h2F);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_hold_valid", cw_valid, 1);
            chk("t5_hold_data",  cw_data, 21'b11011001);
            chk("t5_hold_len",   cw_length, 8);
            chk("t5_hold_ready", sym_ready, 0);
        end
        cw_ready = 1'b1;
        @(negedge clk);
        chk("t5_valid_after", cw_valid, 0);
        chk("t5_ready_after", sym_ready, 1);
        chk("t5_count",       cw_count, CNT_EXP);

        // Overflow on the depth-4 instance
        send(4'h5); @(negedge clk);
        send(4'h5); @(negedge clk);
        send(4'h5); @(negedge clk);
        chk("t4_ovf_early", overflow4, 0);
        send(4'h5); @(negedge clk);
        chk("t4_ovf",      overflow4, 1);
        chk("t4_ovf_main", overflow, 0);
        send(4'hF);
        chk("t4_apcnt",  ap_cnt4, 1);
        chk("t4_apdata", ap_data4, 64'hF);
        @(negedge clk);
        chk("t4_valid",       cw_valid4, 1);
        chk("t4_data",        cw_data4, 21'b101000);
        chk("t4_len",         cw_length4, 6);
        chk("t4_ovf_sticky",  overflow4, 1);
        chk("t4_main_nohit",  cw_valid, 0);
        @(negedge clk);

        rst_n = 1'b0; @(negedge clk); @(negedge clk); rst_n = 1'b1; @(negedge clk);

        // Reset during EMIT
        cw_ready = 1'b0;
        send(4'hF); @(negedge clk);
        chk("t6_valid", cw_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_valid", cw_valid, 0);
        chk("t6_rst_ready", sym_ready, 0);
        chk("t6_rst_busy",  busy, 0);
        chk("t6_rst_count", cw_count, 0);
        rst_n = 1'b1; cw_ready = 1'b1;
        @(negedge clk);
        chk("t6_ready", sym_ready, 1);
        chk("t6_novalid", cw_valid, 0);
        send(4'h2);
        chk("t6_apcnt",  ap_cnt, 1);
        chk("t6_apdata", ap_data, 64'h2);
        @(negedge clk); @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/le_prefix_sequencer.md
# le_prefix_sequencer

Sequencer for the low-entropy codebook lookup in the hybrid entropy coder. It accepts one 4-bit low-entropy symbol at a time and builds the active prefix. Each new symbol is presented to a combinational codebook (prefix count plus right-aligned prefix nibbles). On a match it emits the codeword; on a miss it appends the symbol and waits for the next one. It also handles end-of-segment flush of a partial prefix, prefix overflow, and output backpressure. It sits between the low-entropy symbol source and the bit packer, with one codebook instance hung off its query port.

## Interface
- CODEBOOK_LENGTH_MAX, 64, codebook query data width in bits; must be a multiple of 4.
- ENCODE_DATALENGTH, 21, codeword width from the codebook.
- MAX_DEPTH, 16, maximum symbols in a candidate prefix; MAX_DEPTH*4 ≤ CODEBOOK_LENGTH_MAX.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset; synchronous, active-low.
- sym_valid_i  in  1  symbol offered.
- sym_i  in  4  symbol; 0x0..0xE are literal symbols, 0xF is the escape symbol.
- sym_ready_o  out  1  symbol accepted when high together with sym_valid_i.
- flush_i  in  1  end-of-segment flush request (level; sampled per Operation).
- ap_cnt_o  out  6  codebook query: number of nibbles in the candidate.
- ap_data_o  out  CODEBOOK_LENGTH_MAX  codebook query: candidate nibbles, oldest in the highest used nibble, newest in [3:0], zero-extended.
- encode_match_i  in  1  codebook hit.
- encode_length_i  in  6  codeword length.
- encode_data_i  in  ENCODE_DATALENGTH  codeword, right-aligned.
- cw_valid_o  out  1  output word valid.
- cw_ready_i  in  1  downstream ready.
- cw_data_o  out  ENCODE_DATALENGTH  codeword; 0 for flush words.
- cw_length_o  out  6  codeword length; 0 for flush words.
- cw_flush_o  out  1  the word is a flush record, not a codeword.
- flush_cnt_o  out  6  number of nibbles in the flushed prefix.
- flush_data_o  out  CODEBOOK_LENGTH_MAX  flushed prefix, packed like ap_data_o.
- flush_done_o  out  1  one-cycle pulse when a flush completes.
- overflow_o  out  1  sticky: a prefix overflow has occurred.
- busy_o  out  1  high whenever the FSM is not in IDLE.
- cw_count_o  out  16  count of emitted codewords (see Configuration).

## Operation
- Internal state: prefix register, pfx_len (0..MAX_DEPTH-1), flush_pend.
- FSM states: IDLE, LOOKUP, EMIT, FLUSH.
- **IDLE**
  - sym_ready_o = 1.
  - On sym_valid_i: latch ap_cnt_o = pfx_len+1 and ap_data_o = {prefix, sym_i}, then go to LOOKUP.
  - Otherwise, if flush_i or flush_pend is set, go to FLUSH.
- **LOOKUP**
  - ap_cnt_o and ap_data_o are driven to the codebook; encode_* are sampled at the end of the cycle.
  - Match: load cw_data_o = encode_data_i and cw_length_o = encode_length_i, set cw_flush_o = 0, clear the prefix (pfx_len = 0), go to EMIT.
  - Miss with pfx_len+1 < MAX_DEPTH: the prefix becomes the candidate, pfx_len increments, go to IDLE.
  - Miss with pfx_len+1 = MAX_DEPTH: set overflow_o, clear the prefix, drop the symbol, go to IDLE.
- **EMIT**
  - cw_valid_o = 1; outputs are held stable until cw_ready_i.
  - On transfer (cw_valid_o & cw_ready_i): if this was a flush word, pulse flush_done_o. Then go to IDLE.
- **FLUSH**
  - pfx_len = 0: pulse flush_done_o, clear flush_pend, go to IDLE. No output word is produced.
  - pfx_len > 0: load cw_flush_o = 1, flush_cnt_o = pfx_len, flush_data_o = prefix, cw_data_o = 0, cw_length_o = 0. Clear the prefix and flush_pend, go to EMIT.
- flush_i asserted in any state other than IDLE, or together with sym_valid_i in IDLE, sets flush_pend. The symbol is processed first; the flush follows.
- ap_cnt_o and ap_data_o are forced to 0 outside LOOKUP. The codebook then reports a miss, so idle cycles cannot produce false hits.
- Arithmetic: ap_cnt_o = pfx_len + 1 ≤ MAX_DEPTH. No wrap-around is possible.

## Timing
- Reset values: every output is 0, including overflow_o and cw_count_o; the FSM is in IDLE; prefix, pfx_len and flush_pend are 0. sym_ready_o becomes 1 in the first cycle after reset is released.
- Symbol accepted in cycle N:
  - LOOKUP in cycle N+1.
  - On a match, cw_valid_o = 1 from cycle N+2.
  - On a miss, sym_ready_o = 1 again in cycle N+2.
- Peak throughput is 1 symbol per 2 cycles with no backpressure.
- Word transferred in cycle M: IDLE in cycle M+1, with sym_ready_o = 1.
- Flush with an empty prefix: flush_done_o is high in the cycle after FLUSH is entered.
- Reset asserted mid-operation: all state is discarded on the next clock edge. A pending word is lost and is not re-emitted.

## Configuration
- LE_SEQ_STATS_EN defined:
  - cw_count_o increments on each transfer with cw_flush_o = 0.
  - The count saturates at 0xFFFF and is cleared by reset.
- LE_SEQ_STATS_EN undefined:
  - The counter logic is removed and cw_count_o is tied to 0.
  - All other behaviour is identical.

## Test plan
- Codebook b3 attached, reset released, sym 0xF, cw_ready_i = 1 → ap_cnt_o = 1 and ap_data_o = 0xF in cycle N+1; cw_length_o = 6, cw_data_o = 0b101000 in cycle N+2; then IDLE.
- Symbols 0, 0, 1, 0xF → three misses, then query ap_cnt_o = 4, ap_data_o = 0x001F; output cw_length_o = 12, cw_data_o = 0xFF9; pfx_len = 0 afterwards.
- Symbols 2, 2, then flush_i → output word with cw_flush_o = 1, flush_cnt_o = 2, flush_data_o = 0x22; flush_done_o pulses on the transfer; an immediate second flush only pulses flush_done_o.
- MAX_DEPTH = 4, symbols 5, 5, 5, 5 → four misses; overflow_o = 1 after the fourth LOOKUP and stays set; the next symbol 0xF yields the 6-bit codeword 0b101000.
- Symbol 2, 0xF with cw_ready_i held low for 5 cycles → cw_valid_o, cw_data_o = 0b11011001 and cw_length_o = 8 stay stable and sym_ready_o stays low; the word transfers when cw_ready_i rises; LE_SEQ_STATS_EN build shows cw_count_o = 1.
- rst_n_i pulled low during EMIT → cw_valid_o = 0 and the prefix is cleared at the next edge; sym_ready_o = 1 in the first cycle after release.
